// File: rtl/icache_pkg.sv
// Shared definitions for the icache miss path.
//   tag_bits()   : derives the tag width from address, set-index and offset widths
//   OFFSET_BITS  : byte-in-block offset width of the default configuration
//   miss_entry_t : {tag, setid, wid} record for the default configuration
package icache_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned SETIDX_DEF       = 5;
  localparam int unsigned BLOCK_OFFSET_DEF = 1;
  localparam int unsigned WORD_OFFSET_DEF  = 1;
  localparam int unsigned WID_DEF          = 3;

  localparam int unsigned OFFSET_BITS = BLOCK_OFFSET_DEF + WORD_OFFSET_DEF;

  function automatic int unsigned tag_bits(input int unsigned xlen,
                                           input int unsigned setidx_bits,
                                           input int unsigned block_off_bits,
                                           input int unsigned word_off_bits);
    return xlen - setidx_bits - block_off_bits - word_off_bits;
  endfunction

  localparam int unsigned TAG_DEF =
      tag_bits(XLEN_DEF, SETIDX_DEF, BLOCK_OFFSET_DEF, WORD_OFFSET_DEF);

  typedef struct packed {
    logic [TAG_DEF-1:0]    tag;
    logic [SETIDX_DEF-1:0] setid;
    logic [WID_DEF-1:0]    wid;
  } miss_entry_t;

endpackage

// File: rtl/icache_miss_fifo.sv
// Generic circular FIFO with occupancy count and synchronous flush.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : drop all entries at the next edge (beats push/pop)
//   push, wdata         : write request (ignored when full)
//   pop, rdata          : read request (ignored when empty), head entry
//   count, full, empty  : occupancy
//   entries, entry_valid: raw storage and per-slot occupancy, for external comparators
module icache_miss_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic [CntW-1:0]             count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][WIDTH-1:0] entries,
  output logic [DEPTH-1:0]            entry_valid
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q;
  logic                        do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign entries = mem_q;

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PtrW-1:0] offs;
    entry_valid = '0;
    offs        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs           = PtrW'(i) - rd_ptr_q;
      entry_valid[i] = (CntW'(offs) < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/icache_miss_req_gen.sv
// Instruction-cache miss request generator: queues missed {tag, setid, wid},
// rebuilds the line-aligned block address and issues it over valid/ready.
// Optional feature macro: ICACHE_MISS_MERGE_EN -- a miss whose {tag, setid}
// matches a queued entry is accepted without being enqueued (even when full).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   miss_valid_i/miss_ready_o        : miss handshake
//   miss_tag_i, miss_setid_i, miss_wid_i : missed line and requesting warp
//   mem_req_valid_o/mem_req_ready_i  : memory request handshake
//   mem_req_addr_o, mem_req_wid_o    : head entry block address and warp id
//   flush_i                          : discard all queued misses
module icache_miss_req_gen
  import icache_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned SETIDXBITS       = 5,
  parameter int unsigned BLOCK_OFFSETBITS = 1,
  parameter int unsigned WORD_OFFSETBITS  = 1,
  parameter int unsigned WID_BITS         = 3,
  parameter int unsigned DEPTH            = 4,
  localparam int unsigned TAG_BITS =
      tag_bits(XLEN, SETIDXBITS, BLOCK_OFFSETBITS, WORD_OFFSETBITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [TAG_BITS-1:0]   miss_tag_i,
  input  logic [SETIDXBITS-1:0] miss_setid_i,
  input  logic [WID_BITS-1:0]   miss_wid_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [XLEN-1:0]       mem_req_addr_o,
  output logic [WID_BITS-1:0]   mem_req_wid_o,
  input  logic                  flush_i
);

  localparam int unsigned OffBits   = BLOCK_OFFSETBITS + WORD_OFFSETBITS;
  localparam int unsigned EntryBits = TAG_BITS + SETIDXBITS + WID_BITS;
  localparam int unsigned CntW      = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [SETIDXBITS-1:0] setid;
    logic [WID_BITS-1:0]   wid;
  } entry_t;

  entry_t                          in_entry, head;
  logic [EntryBits-1:0]            head_raw;
  logic [DEPTH-1:0][EntryBits-1:0] entries;
  logic [DEPTH-1:0]                entry_valid;
  logic [CntW-1:0]                 count;
  logic                            full, empty;
  logic                            push, pop;

  assign in_entry = '{tag: miss_tag_i, setid: miss_setid_i, wid: miss_wid_i};

`ifdef ICACHE_MISS_MERGE_EN
  logic hit;

  always_comb begin
    entry_t e;
    hit = 1'b0;
    e   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = entry_t'(entries[i]);
      if (entry_valid[i] && (e.tag == miss_tag_i) && (e.setid == miss_setid_i)) begin
        hit = 1'b1;
      end
    end
  end

  // A duplicate is absorbed: the pending refill wakes every warp on that line.
  assign miss_ready_o = (~full | hit) & ~flush_i;
  assign push         = miss_valid_i & miss_ready_o & ~hit;
`else
  logic unused_merge_taps;
  assign unused_merge_taps = ^{entries, entry_valid};

  assign miss_ready_o = ~full & ~flush_i;
  assign push         = miss_valid_i & miss_ready_o;
`endif

  assign mem_req_valid_o = ~empty;
  assign pop             = mem_req_valid_o & mem_req_ready_i;

  assign head           = entry_t'(head_raw);
  assign mem_req_addr_o = {head.tag, head.setid, {OffBits{1'b0}}};
  assign mem_req_wid_o  = head.wid;

  icache_miss_fifo #(
    .WIDTH(EntryBits),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_i),
    .push       (push),
    .wdata      (in_entry),
    .pop        (pop),
    .rdata      (head_raw),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .entries    (entries),
    .entry_valid(entry_valid)
  );

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_icache_miss_req_gen.sv
module tb_icache_miss_req_gen;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [24:0] miss_tag_i;
  logic [4:0]  miss_setid_i;
  logic [2:0]  miss_wid_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic [2:0]  mem_req_wid_o;
  logic        flush_i;

  always #5 clk = ~clk;

  icache_miss_req_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .miss_valid_i   (miss_valid_i),
    .miss_ready_o   (miss_ready_o),
    .miss_tag_i     (miss_tag_i),
    .miss_setid_i   (miss_setid_i),
    .miss_wid_i     (miss_wid_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_wid_o  (mem_req_wid_o),
    .flush_i        (flush_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  wid;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef ICACHE_MISS_MERGE_EN
  localparam bit MergeOn = 1'b1;
`else
  localparam bit MergeOn = 1'b0;
`endif

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] blk_addr(input miss_entry_t m);
    return {m.tag, m.setid, 2'b00};
  endfunction

  function automatic miss_entry_t mk(input logic [24:0] tag, input logic [4:0] setid,
                                     input logic [2:0] wid);
    miss_entry_t m;
    m.tag   = tag;
    m.setid = setid;
    m.wid   = wid;
    return m;
  endfunction

  // Monitor: every request transfer must match the oldest expected entry.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n === 1'b1 && mem_req_valid_o === 1'b1 && mem_req_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got addr 0x%0h wid %0d, expected no request",
                   mem_req_addr_o, mem_req_wid_o);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", mem_req_addr_o, e.addr);
          check("req_wid", 32'(mem_req_wid_o), 32'(e.wid));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one miss for one cycle; check acceptance; optionally expect it issued.
  task automatic send_miss(input miss_entry_t m, input logic exp_acc, input logic issue,
                           input string name);
    exp_t e;
    miss_valid_i = 1'b1;
    miss_tag_i   = m.tag;
    miss_setid_i = m.setid;
    miss_wid_i   = m.wid;
    @(negedge clk);
    check(name, 32'(miss_ready_o), 32'(exp_acc));
    @(posedge clk);
    if (exp_acc && issue) begin
      e.addr = blk_addr(m);
      e.wid  = m.wid;
      exp_q.push_back(e);
    end
    #1;
    miss_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    mem_req_ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({name, "_valid_low"}, 32'(mem_req_valid_o), 32'd0);
    tick();
  endtask

  miss_entry_t bp[4];
  miss_entry_t v5, vf;
  exp_t        e1;

  initial begin
    rst_n           = 1'b0;
    miss_valid_i    = 1'b0;
    miss_tag_i      = '0;
    miss_setid_i    = '0;
    miss_wid_i      = '0;
    mem_req_ready_i = 1'b0;
    flush_i         = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_ready", 32'(miss_ready_o), 32'd1);
    check("rst_addr", mem_req_addr_o, 32'd0);
    check("rst_wid", 32'(mem_req_wid_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single miss, ready held high: {0x1234567, 5, 2'b00} = 0x91A2B394
    mem_req_ready_i = 1'b1;
    send_miss(mk(25'h1234567, 5'd5, 3'd2), 1'b1, 1'b0, "t1_ready");
    e1.addr = 32'h91A2B394;
    e1.wid  = 3'd2;
    exp_q.push_back(e1);
    @(negedge clk);
    check("t1_valid_next_cycle", 32'(mem_req_valid_o), 32'd1);
    tick();
    @(negedge clk);
    check("t1_dequeued", 32'(mem_req_valid_o), 32'd0);
    tick();

    // Backpressure: fill the queue, stall a fifth miss
    mem_req_ready_i = 1'b0;
    bp[0] = mk(25'h1ABCDEF, 5'd31, 3'd7);
    bp[1] = mk(25'h0000000, 5'd0, 3'd0);
    bp[2] = mk(25'h1FFFFFF, 5'd1, 3'd3);
    bp[3] = mk(25'h0555555, 5'd10, 3'd5);
    for (int i = 0; i < 4; i++) send_miss(bp[i], 1'b1, 1'b1, "t2_push");
    @(negedge clk);
    check("t2_full_ready_low", 32'(miss_ready_o), 32'd0);
    tick();
    v5           = mk(25'h0F0F0F0, 5'd17, 3'd6);
    miss_valid_i = 1'b1;
    miss_tag_i   = v5.tag;
    miss_setid_i = v5.setid;
    miss_wid_i   = v5.wid;
    repeat (2) begin
      @(negedge clk);
      check("t2_stall", 32'(miss_ready_o), 32'd0);
      tick();
    end

    // Full with simultaneous dequeue: rejected this cycle, accepted the next
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    check("t3_full_deq_reject", 32'(miss_ready_o), 32'd0);
    tick();
    @(negedge clk);
    check("t3_accept_next", 32'(miss_ready_o), 32'd1);
    @(posedge clk);
    e1.addr = blk_addr(v5);
    e1.wid  = v5.wid;
    exp_q.push_back(e1);
    #1;
    miss_valid_i = 1'b0;
    drain("t2");

    // Flush with a concurrent miss
    mem_req_ready_i = 1'b0;
    send_miss(mk(25'h0000011, 5'd2, 3'd1), 1'b1, 1'b1, "t4_push");
    send_miss(mk(25'h0000022, 5'd4, 3'd2), 1'b1, 1'b1, "t4_push");
    send_miss(mk(25'h0000033, 5'd6, 3'd3), 1'b1, 1'b1, "t4_push");
    vf           = mk(25'h0000044, 5'd8, 3'd4);
    miss_valid_i = 1'b1;
    miss_tag_i   = vf.tag;
    miss_setid_i = vf.setid;
    miss_wid_i   = vf.wid;
    flush_i      = 1'b1;
    @(negedge clk);
    check("t4_flush_ready_low", 32'(miss_ready_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i      = 1'b0;
    miss_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t4_flush_valid_low", 32'(mem_req_valid_o), 32'd0);
    check("t4_flush_ready_high", 32'(miss_ready_o), 32'd1);
    tick();
    mem_req_ready_i = 1'b1;
    send_miss(mk(25'h0000055, 5'd9, 3'd5), 1'b1, 1'b1, "t4_after");
    drain("t4");

    // Duplicate miss with room in the queue
    mem_req_ready_i = 1'b0;
    send_miss(mk(25'h000000B, 5'd1, 3'd1), 1'b1, 1'b1, "t5_first");
    send_miss(mk(25'h000000B, 5'd1, 3'd4), 1'b1, !MergeOn, "t5_dup");
    drain("t5");

    // Duplicate miss against a full queue
    mem_req_ready_i = 1'b0;
    send_miss(mk(25'h000000A, 5'd3, 3'd1), 1'b1, 1'b1, "t6_fill");
    send_miss(mk(25'h000000C, 5'd3, 3'd2), 1'b1, 1'b1, "t6_fill");
    send_miss(mk(25'h000000A, 5'd2, 3'd3), 1'b1, 1'b1, "t6_fill");
    send_miss(mk(25'h000000B, 5'd3, 3'd4), 1'b1, 1'b1, "t6_fill");
    send_miss(mk(25'h000000A, 5'd3, 3'd5), MergeOn, 1'b0, "t6_dup_full");
    send_miss(mk(25'h000000A, 5'd4, 3'd6), 1'b0, 1'b0, "t6_nondup_full");
    @(negedge clk);
    check("t6_still_full", 32'(miss_ready_o), 32'd0);
    tick();
    drain("t6");

    // Asynchronous reset mid-stream
    mem_req_ready_i = 1'b0;
    send_miss(mk(25'h0123456, 5'd12, 3'd2), 1'b1, 1'b1, "t7_push");
    send_miss(mk(25'h0654321, 5'd21, 3'd3), 1'b1, 1'b1, "t7_push");
    @(negedge clk);
    check("t7_valid_before_rst", 32'(mem_req_valid_o), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async_valid", 32'(mem_req_valid_o), 32'd0);
    check("t7_async_ready", 32'(miss_ready_o), 32'd1);
    check("t7_async_addr", mem_req_addr_o, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("t7_empty_after", 32'(mem_req_valid_o), 32'd0);
    tick();
    mem_req_ready_i = 1'b1;
    send_miss(mk(25'h1000001, 5'd30, 3'd7), 1'b1, 1'b1, "t7_after");
    drain("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
